// File: rtl/pistormx_pkg.sv
// Shared types and constants for the PiStorm-X bus-operation arbiter.
package pistormx_pkg;
  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;
  localparam int CTL_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

  localparam int REQ_PI  = 0;
  localparam int REQ_AUX = 1;

  // CTL = {rw, sz, a0}; rw=1 is a read, sz=0 is a word access.
  localparam int CTL_RW = 2;
  localparam int CTL_SZ = 1;
  localparam int CTL_A0 = 0;

  localparam logic [CTL_W-1:0]  CTL_RESET = 3'b100;
  localparam logic [DATA_W-1:0] ERR_DATA  = 16'hFFFF;

  function automatic logic [1:0] grant_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: on a tie the requester not granted last wins.
module rr_arb2
  import pistormx_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  output logic       idx,
  output logic       gnt_vld
);
  always_comb begin
    gnt_vld = |valid;
    if (valid == 2'b11)
      idx = ~last;
    else if (valid[REQ_PI])
      idx = 1'(REQ_PI);
    else
      idx = valid[REQ_AUX];
  end
endmodule

// File: rtl/bus_op_arbiter.sv
// Arbitrates two command sources onto a single M68K bus engine, with a
// completion timeout that aborts the engine and answers with an error.
module bus_op_arbiter
  import pistormx_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYC = 8'd200
) (
  input  logic              M68K_CLK,
  input  logic              RESET_n,
  input  logic [1:0]        REQ_VALID,
  output logic [1:0]        REQ_READY,
  input  logic [ADDR_W-1:0] REQ0_A,
  input  logic [ADDR_W-1:0] REQ1_A,
  input  logic [DATA_W-1:0] REQ0_D,
  input  logic [DATA_W-1:0] REQ1_D,
  input  logic [CTL_W-1:0]  REQ0_CTL,
  input  logic [CTL_W-1:0]  REQ1_CTL,
  output logic [1:0]        RSP_VALID,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              RSP_ERR,
  output logic              ENG_START,
  output logic [ADDR_W-1:0] ENG_A,
  output logic [DATA_W-1:0] ENG_D,
  output logic [CTL_W-1:0]  ENG_CTL,
  input  logic              ENG_BUSY,
  input  logic              ENG_DONE,
  input  logic [DATA_W-1:0] ENG_RDATA,
  output logic              ENG_ABORT
);
  arb_state_t state;
  logic       last;
  logic       gidx;
  logic [7:0] cnt;
  logic       arb_idx;
  logic       arb_vld;
  logic       grant;
  logic       timeout;

  rr_arb2 u_rr (
    .valid   (REQ_VALID),
    .last    (last),
    .idx     (arb_idx),
    .gnt_vld (arb_vld)
  );

  // READY is a same-cycle handshake so a requester that drops VALID first is
  // never accepted; it stays low while a response is still on the bus.
  assign grant     = RESET_n && (state == IDLE) && arb_vld && (RSP_VALID == 2'b00);
  assign REQ_READY = grant ? grant_onehot(arb_idx) : 2'b00;
  assign ENG_START = RESET_n && (state == ISSUE) && !ENG_BUSY;

  // cnt holds completed WAIT cycles, so this cycle is number cnt+1 after START.
  assign timeout   = RESET_n && (state == WAIT) && !ENG_DONE &&
                     (cnt == TIMEOUT_CYC - 8'd1);
  assign ENG_ABORT = timeout;

  always_ff @(posedge M68K_CLK) begin
    if (!RESET_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      gidx      <= 1'b0;
      cnt       <= 8'd0;
      RSP_VALID <= 2'b00;
      RSP_ERR   <= 1'b0;
      RSP_DATA  <= '0;
      ENG_A     <= '0;
      ENG_D     <= '0;
      ENG_CTL   <= CTL_RESET;
    end else begin
      RSP_VALID <= 2'b00;
      RSP_ERR   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            ENG_A   <= arb_idx ? REQ1_A   : REQ0_A;
            ENG_D   <= arb_idx ? REQ1_D   : REQ0_D;
            ENG_CTL <= arb_idx ? REQ1_CTL : REQ0_CTL;
            gidx    <= arb_idx;
            last    <= arb_idx;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (!ENG_BUSY) begin
            cnt   <= 8'd0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 8'hFF)
            cnt <= cnt + 8'd1;
          if (ENG_DONE) begin
            RSP_VALID <= grant_onehot(gidx);
            RSP_DATA  <= ENG_CTL[CTL_RW] ? ENG_RDATA : '0;
            state     <= IDLE;
          end else if (timeout) begin
            RSP_VALID <= grant_onehot(gidx);
            RSP_ERR   <= 1'b1;
            RSP_DATA  <= ERR_DATA;
            state     <= RECOVER;
          end
        end
        RECOVER: begin
          if (!ENG_BUSY)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_op_arbiter.sv
// Randomised bench for bus_op_arbiter against a transaction-level model.
module tb_bus_op_arbiter;
  localparam logic [7:0] TO = 8'd10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid;
  logic [22:0] req0_a, req1_a, eng_a;
  logic [15:0] req0_d, req1_d, eng_d, rsp_data, eng_rdata;
  logic [2:0]  req0_ctl, req1_ctl, eng_ctl;
  logic        rsp_err, eng_start, eng_busy, eng_done, eng_abort;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  bit mdl_last;
  logic [22:0] op_a [2];
  logic [15:0] op_d [2];
  logic [2:0]  op_c [2];

  always #5 clk = ~clk;

  bus_op_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .M68K_CLK (clk),       .RESET_n  (rst_n),
    .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ0_A   (req0_a),    .REQ1_A   (req1_a),
    .REQ0_D   (req0_d),    .REQ1_D   (req1_d),
    .REQ0_CTL (req0_ctl),  .REQ1_CTL (req1_ctl),
    .RSP_VALID(rsp_valid), .RSP_DATA (rsp_data), .RSP_ERR(rsp_err),
    .ENG_START(eng_start), .ENG_A    (eng_a),    .ENG_D  (eng_d),
    .ENG_CTL  (eng_ctl),   .ENG_BUSY (eng_busy), .ENG_DONE(eng_done),
    .ENG_RDATA(eng_rdata), .ENG_ABORT(eng_abort)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic rand_ops();
    for (int r = 0; r < 2; r++) begin
      op_a[r] = 23'($urandom);
      op_d[r] = 16'($urandom);
      op_c[r] = 3'($urandom);
    end
  endtask

  task automatic drive_ops();
    req0_a = op_a[0]; req0_d = op_d[0]; req0_ctl = op_c[0];
    req1_a = op_a[1]; req1_d = op_d[1]; req1_ctl = op_c[1];
  endtask

  // One complete command: grant, optional busy stall, wait, response, recovery.
  // done_dly = 0 or beyond TO means the engine never completes.
  task automatic run_op(input logic [1:0] mask, input int busy_pre, input int done_dly,
                        input logic [15:0] rdata, input int rec_busy, input bit jitter,
                        output int got_g);
    int g, og, n;
    bit to_case;
    logic [15:0] exp_data;
    to_case = (done_dly == 0) || (done_dly > int'(TO));
    g  = (mask == 2'b11) ? (mdl_last ? 0 : 1) : (mask[1] ? 1 : 0);
    og = 1 - g;
    got_g = -1;

    @(negedge clk);
    drive_ops();
    req_valid = mask; eng_done = 1'b0; eng_busy = 1'b0;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 4) begin
      @(negedge clk); #1; n++;
    end
    check_eq("grant_latency", n, 0);
    if (req_ready == 2'b00) return;
    check_eq("req_ready", req_ready, onehot(g));
    got_g = req_ready[1] ? 1 : 0;
    mdl_last = (g == 1);

    for (int i = 0; i <= busy_pre; i++) begin
      @(negedge clk);
      req_valid = mask & ~onehot(g);
      if (jitter) req_valid[og] = 1'($urandom);
      eng_busy = (i < busy_pre);
      eng_done = (i < busy_pre) ? 1'($urandom) : 1'b0;
      #1;
      check_eq("ready_busy", req_ready, 2'b00);
      if (i < busy_pre) check_eq("start_held", eng_start, 1'b0);
      else              check_eq("start", eng_start, 1'b1);
    end
    check_eq("eng_latch", {eng_a, eng_d, eng_ctl}, {op_a[g], op_d[g], op_c[g]});

    for (int k = 1; k <= int'(TO); k++) begin
      @(negedge clk);
      eng_busy  = 1'b1;
      eng_done  = !to_case && (k == done_dly);
      eng_rdata = eng_done ? rdata : 16'($urandom);
      if (jitter) req_valid[og] = 1'($urandom);
      #1;
      check_eq("abort", eng_abort, to_case && (k == int'(TO)));
      if (eng_done) break;
    end

    @(negedge clk);
    eng_done  = 1'b0;
    eng_busy  = to_case ? (rec_busy > 0) : 1'b0;
    req_valid = mask;
    #1;
    exp_data = to_case ? 16'hFFFF : (op_c[g][2] ? rdata : 16'h0000);
    check_eq("rsp_valid", rsp_valid, onehot(g));
    check_eq("rsp_err", rsp_err, to_case);
    check_eq("rsp_data", rsp_data, exp_data);
    check_eq("ready_in_rsp", req_ready, 2'b00);
    check_eq("eng_hold", {eng_a, eng_d, eng_ctl}, {op_a[g], op_d[g], op_c[g]});

    if (to_case && rec_busy > 0) begin
      for (int j = 1; j <= rec_busy; j++) begin
        @(negedge clk);
        eng_busy = (j < rec_busy);
        eng_done = 1'($urandom);
        #1;
        check_eq("recover_ready", req_ready, 2'b00);
        check_eq("recover_rsp", rsp_valid, 2'b00);
      end
    end
  endtask

  task automatic reset_mid();
    rand_ops();
    @(negedge clk);
    drive_ops();
    req_valid = 2'b01; eng_busy = 1'b0; eng_done = 1'b0;
    #1;
    check_eq("rm_ready", req_ready, 2'b01);
    mdl_last = 1'b0;
    @(negedge clk); req_valid = 2'b00; #1;
    check_eq("rm_start", eng_start, 1'b1);
    repeat (3) begin
      @(negedge clk); eng_busy = 1'b1; #1;
    end
    @(negedge clk); rst_n = 1'b0; #1;
    @(negedge clk); rst_n = 1'b1; eng_busy = 1'b0; #1;
    check_eq("rm_ctrl", {req_ready, rsp_valid, rsp_err, eng_start, eng_abort}, 0);
    check_eq("rm_data", {rsp_data, eng_a, eng_d}, 0);
    check_eq("rm_ctl", eng_ctl, 3'b100);
    mdl_last = 1'b1;
    repeat (3) begin
      @(negedge clk); eng_done = 1'b1; #1;
      check_eq("rm_no_rsp", rsp_valid, 2'b00);
    end
    eng_done = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      #2;
      check_eq("mon_ready_1hot", $countones(req_ready) <= 1, 1'b1);
      check_eq("mon_rsp_1hot", $countones(rsp_valid) <= 1, 1'b1);
      check_eq("mon_excl", (|req_ready) && (|rsp_valid), 1'b0);
    end
  end

  initial begin
    int got;
    int gnt_mask;
    int busy_pre, done_dly, rec_busy;
    rst_n = 1'b0; req_valid = 2'b11; eng_busy = 1'b0; eng_done = 1'b0;
    eng_rdata = 16'h0;
    rand_ops(); drive_ops();
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ctrl", {req_ready, rsp_valid, rsp_err, eng_start, eng_abort}, 0);
    check_eq("rst_data", {rsp_data, eng_a, eng_d}, 0);
    check_eq("rst_ctl", eng_ctl, 3'b100);
    mdl_last = 1'b1;
    mon_en = 1'b1;
    @(negedge clk); rst_n = 1'b1; req_valid = 2'b00;

    // Both requesters continuously valid from reset: strict alternation.
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      run_op(2'b11, 0, 4, 16'($urandom), 0, 1'b0, got);
      check_eq("tie_order", got, i % 2);
    end

    rand_ops();
    op_a[0] = 23'h7FF000; op_c[0] = 3'b100;
    run_op(2'b01, 0, 6, 16'hBEEF, 0, 1'b0, got);

    rand_ops();
    run_op(2'b01, 5, 3, 16'($urandom), 0, 1'b0, got);

    rand_ops();
    run_op(2'b10, 0, 0, 16'($urandom), 3, 1'b0, got);

    rand_ops();
    op_c[0][2] = 1'b1;
    run_op(2'b01, 0, int'(TO), 16'h1234, 0, 1'b0, got);

    reset_mid();
    rand_ops();
    run_op(2'b11, 0, 2, 16'($urandom), 0, 1'b0, got);
    check_eq("tie_after_reset", got, 0);

    for (int i = 0; i < 30; i++) begin
      rand_ops();
      gnt_mask = $urandom_range(1, 3);
      busy_pre = $urandom_range(0, 3);
      done_dly = $urandom_range(0, 12);
      rec_busy = $urandom_range(0, 3);
      run_op(2'(gnt_mask), busy_pre, done_dly, 16'($urandom), rec_busy, 1'b1, got);
    end

    mon_en = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_op_arbiter.md
BUS_OP_ARBITER -- requirements
Module: bus_op_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 8'd200, the number of M68K_CLK cycles allowed for ENG_DONE after ENG_START.
REQ-002 SHALL have port M68K_CLK  in  1  the single clock (7 MHz bus clock); all logic on its rising edge.
REQ-003 SHALL have port RESET_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have port REQ_VALID  in  2  per requester (bit0 = Pi host, bit1 = auxiliary): command pending.
REQ-005 SHALL have port REQ_READY  out  2  per requester: command accepted this cycle.
REQ-006 SHALL have ports REQ0_A/REQ1_A  in  23  address[23:1]; REQ0_D/REQ1_D  in  16  write data; REQ0_CTL/REQ1_CTL  in  3  {rw, sz, a0}.
REQ-007 SHALL have port RSP_VALID  out  2  one-cycle response pulse to the granted requester.
REQ-008 SHALL have ports RSP_DATA  out  16  read data, and RSP_ERR  out  1  timeout flag, shared and valid with RSP_VALID.
REQ-009 SHALL have ports ENG_START  out  1  one-cycle start pulse; ENG_A  out  23; ENG_D  out  16; ENG_CTL  out  3 {rw, sz, a0}.
REQ-010 SHALL have ports ENG_BUSY  in  1  engine not in S0; ENG_DONE  in  1  one-cycle S7 completion; ENG_RDATA  in  16; ENG_ABORT  out  1  one-cycle pulse that forces the engine back to S0.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT, RECOVER.
REQ-012 In IDLE with exactly one REQ_VALID bit set, SHALL grant that requester.
REQ-013 In IDLE with both bits set, SHALL grant the requester not granted last (round-robin).
REQ-014 On grant, SHALL assert REQ_READY for one cycle, latch A/D/CTL into ENG_* registers, record the grant index, and go to ISSUE.
REQ-015 Deasserting REQ_VALID before REQ_READY SHALL leave that request ungranted, with no side effects.
REQ-016 In ISSUE with ENG_BUSY=0, SHALL pulse ENG_START for one cycle, clear the timeout counter, and go to WAIT; with ENG_BUSY=1, SHALL stay in ISSUE without starting the counter.
REQ-017 ENG_A/ENG_D/ENG_CTL SHALL stay stable from grant until the state returns to IDLE.
REQ-018 In WAIT, ENG_DONE=1 SHALL cause, in the next cycle, RSP_VALID[g]=1 with RSP_ERR=0 and RSP_DATA=ENG_RDATA (read) or 16'h0000 (write); the state then returns to IDLE.
REQ-019 The WAIT counter SHALL be 8 bits, increment each cycle, and saturate.
REQ-020 When the counter reaches TIMEOUT_CYC with no ENG_DONE, SHALL pulse ENG_ABORT and respond with RSP_ERR=1, RSP_DATA=16'hFFFF, then go to RECOVER.
REQ-021 If ENG_DONE and timeout occur in the same cycle, ENG_DONE SHALL win: normal response, no ENG_ABORT.
REQ-022 RECOVER SHALL wait for ENG_BUSY=0, then go to IDLE; ENG_DONE in RECOVER SHALL be ignored.
REQ-023 Outside WAIT, ENG_DONE SHALL be ignored.
REQ-024 Minimum latency SHALL be REQ_READY at N, ENG_START at N+1, RSP_VALID one cycle after ENG_DONE; the earliest next grant is the cycle after RSP_VALID.
REQ-025 At most one RSP_VALID bit and one REQ_READY bit SHALL be high in any cycle, and RSP_VALID and REQ_READY SHALL never be high together.

Reset
REQ-026 With RESET_n=0 at a clock edge, state SHALL be IDLE and REQ_READY, RSP_VALID, RSP_ERR, ENG_START, ENG_ABORT = 0.
REQ-027 Reset SHALL clear RSP_DATA, ENG_A, ENG_D and the counter to 0, set ENG_CTL=3'b100 (read, word), and set last-grant=1 so requester 0 wins the first tie.
REQ-028 Reset during ISSUE/WAIT/RECOVER SHALL drop the in-flight command with no response pulse.

Structure
REQ-029 Shared package pistormx_pkg SHALL hold the state encoding, requester index constants (REQ_PI=0, REQ_AUX=1), CTL bit positions, and the constant ERR_DATA=16'hFFFF.
REQ-030 The two-input round-robin grant logic SHALL be a sub-module rr_arb2 (inputs valid[1:0], last; output grant index and grant-valid).

Verification
REQ-031 Bench SHALL cover: Pi read A=23'h7FF000, ENG_DONE 6 cycles after ENG_START with ENG_RDATA=16'hBEEF -> RSP_VALID[0] once, RSP_DATA=16'hBEEF, RSP_ERR=0.
REQ-032 Bench SHALL cover: both requesters valid from reset, each done in 4 cycles -> grants in order 0,1,0,1, with no REQ_READY in the RSP_VALID cycle.
REQ-033 Bench SHALL cover: TIMEOUT_CYC=10, ENG_DONE never asserted -> ENG_ABORT exactly 10 cycles after ENG_START, RSP_ERR=1, RSP_DATA=16'hFFFF, IDLE only after ENG_BUSY=0.
REQ-034 Bench SHALL cover: ENG_DONE coincident with the timeout cycle -> RSP_ERR=0, no ENG_ABORT.
REQ-035 Bench SHALL cover: ENG_BUSY=1 held 5 cycles after grant -> ENG_START delayed until the first cycle with ENG_BUSY=0.
REQ-036 Bench SHALL cover: RESET_n=0 for one cycle during WAIT -> all outputs 0 next cycle, no RSP_VALID, next tie grants requester 0.
